bsg_axi_burst_responder: RTL

AXI4 subordinate that terminates the full-width INCR bursts issued by the cache DMA-to-AXI bridge and services them from an internal register-array memory. It sits on the memory side of that bridge, as a simulation/FPGA backing store. Read and write bursts are serialized through one state machine; one burst is in flight at a time.

---
 rtl/bsg_axi_burst_responder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_axi_burst_responder.sv
// AXI4 subordinate backing store: serializes full-width INCR read/write bursts into a register-array memory.
// Optional BSG_AXI_BURST_RESPONDER_STALL_EN adds LFSR-driven wready/rvalid back-pressure.
module bsg_axi_burst_responder #(
    parameter int axi_id_width_p   = 4,
    parameter int axi_addr_width_p = 16,
    parameter int axi_data_width_p = 32,
    parameter int mem_els_p        = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [7:0]                    axi_awlen_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,

    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,

    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,

    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [7:0]                    axi_arlen_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,

    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);

    localparam int strb_width_lp     = axi_data_width_p / 8;
    localparam int lg_strb_lp        = $clog2(strb_width_lp);
    localparam int idx_width_lp      = axi_addr_width_p - lg_strb_lp;
    localparam int mem_addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_DATA, WR_RESP} state_e;

    state_e                        state_q, state_d;
    logic [axi_id_width_p-1:0]     id_q, id_d;
    logic [idx_width_lp-1:0]       idx_q, idx_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [7:0]                    len_q, len_d;
    logic                          err_q, err_d;
    logic                          last_grant_q, last_grant_d;
    logic                          rvalid_q, rvalid_d;
    logic                          rlast_q, rlast_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic [axi_data_width_p-1:0]   rdata_q, rdata_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;

    logic [axi_data_width_p-1:0]   mem_q [mem_els_p];
    logic                          mem_we;
    logic                          aw_win, ar_win;
    logic                          rd_load;
    logic                          stall;

`ifdef BSG_AXI_BURST_RESPONDER_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) lfsr_q <= 8'hA5;
        else            lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // A beat index at or beyond the array end is an error beat, never an alias.
    function automatic logic in_range(input logic [idx_width_lp-1:0] idx);
        return 64'(idx) < 64'(mem_els_p);
    endfunction

    // On a tie the channel not granted last time wins; last_grant_q=1 means AR.
    assign aw_win = axi_awvalid_i & (~axi_arvalid_i | last_grant_q);
    assign ar_win = axi_arvalid_i & ~aw_win;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        err_d         = err_q;
        last_grant_d  = last_grant_q;
        rvalid_d      = rvalid_q;
        rlast_d       = rlast_q;
        rresp_d       = rresp_q;
        rdata_d       = rdata_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        axi_awready_o = 1'b0;
        axi_arready_o = 1'b0;
        axi_wready_o  = 1'b0;
        mem_we        = 1'b0;
        rd_load       = 1'b0;

        case (state_q)
            IDLE: begin
                axi_awready_o = aw_win;
                axi_arready_o = ar_win;
                if (aw_win) begin
                    id_d         = axi_awid_i;
                    idx_d        = idx_width_lp'(axi_awaddr_i >> lg_strb_lp);
                    len_d        = axi_awlen_i;
                    cnt_d        = 8'd0;
                    err_d        = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = WR_DATA;
                end else if (ar_win) begin
                    id_d         = axi_arid_i;
                    idx_d        = idx_width_lp'(axi_araddr_i >> lg_strb_lp);
                    len_d        = axi_arlen_i;
                    cnt_d        = 8'd0;
                    err_d        = 1'b0;
                    last_grant_d = 1'b1;
                    rd_load      = ~stall;
                    state_d      = RD_BURST;
                end
            end
            RD_BURST: begin
                if (rvalid_q && axi_rready_i) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + idx_width_lp'(1);
                        cnt_d   = cnt_q + 8'd1;
                        rd_load = ~stall;
                    end
                end else if (!rvalid_q) begin
                    rd_load = ~stall;
                end
            end
            WR_DATA: begin
                axi_wready_o = ~stall;
                if (axi_wvalid_i && !stall) begin
                    mem_we = in_range(idx_q);
                    if (!in_range(idx_q) || (axi_wlast_i != (cnt_q == len_q)))
                        err_d = 1'b1;
                    idx_d = idx_q + idx_width_lp'(1);
                    cnt_d = cnt_q + 8'd1;
                    // Length, not wlast, terminates the burst.
                    if (cnt_q == len_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = err_d ? resp_slverr_lp : resp_okay_lp;
                        state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (axi_bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read payload is registered from the beat index the burst is about to present.
        if (rd_load) begin
            rvalid_d = 1'b1;
            rlast_d  = (cnt_d == len_d);
            if (in_range(idx_d)) begin
                rdata_d = mem_q[idx_d[mem_addr_width_lp-1:0]];
                rresp_d = resp_okay_lp;
            end else begin
                rdata_d = '0;
                rresp_d = resp_slverr_lp;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            id_q         <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rresp_q      <= '0;
            rdata_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
        end
    end

    // Memory contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < strb_width_lp; b++) begin
                if (axi_wstrb_i[b])
                    mem_q[idx_q[mem_addr_width_lp-1:0]][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    assign axi_bid_o    = id_q;
    assign axi_bresp_o  = bresp_q;
    assign axi_bvalid_o = bvalid_q;
    assign axi_rid_o    = id_q;
    assign axi_rdata_o  = rdata_q;
    assign axi_rresp_o  = rresp_q;
    assign axi_rlast_o  = rlast_q;
    assign axi_rvalid_o = rvalid_q;

endmodule
